// File: rtl/xor_word_builder.sv
// XOR word builder: packs a serial XOR bit stream into WIDTH-bit words.
// Optional macro XORW_XNOR_EN packs XNOR bits (matches) instead of XOR bits.
module xor_word_builder #(
  parameter int WIDTH = 128,
  parameter int NW_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [NW_W-1:0]  i_num_words,
  input  logic             i_bit_valid,
  input  logic             i_bit_a,
  input  logic             i_bit_b,
  output logic             o_bit_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [BW-1:0]    bcnt;
  logic             pend;
  logic [NW_W-1:0]  words_left;

  logic new_bit;
  logic accept;
  logic last_bit;
  logic drain;
  logic out_free;
  logic load_new;
  logic load_pend;
  logic load;
  logic last_word;
  logic start_ok;

`ifdef XORW_XNOR_EN
  assign new_bit = ~(i_bit_a ^ i_bit_b);
`else
  assign new_bit = i_bit_a ^ i_bit_b;
`endif

  // A completed word waiting in sr blocks further bits.
  assign o_bit_ready = (state == S_RUN) & ~pend;

  assign accept    = i_bit_valid & o_bit_ready;
  assign last_bit  = accept & (bcnt == BMAX);
  assign drain     = o_valid & i_ready;
  assign out_free  = ~o_valid | drain;
  assign load_new  = last_bit & out_free;
  assign load_pend = pend & out_free;
  assign load      = load_new | load_pend;
  assign last_word = load & (words_left == NW_W'(1));
  assign sr_next   = {sr[WIDTH-2:0], new_bit};
  assign start_ok  = (state == S_IDLE) & i_start;

  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);

  // Job sequencing: idle, stream words, drain last word, done pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            if (i_num_words != '0) state <= S_RUN;
            else                   state <= S_DONE;
          end
        end
        S_RUN: begin
          if (last_word) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shift register, bit counter, pending flag and word budget.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sr         <= '0;
      bcnt       <= '0;
      pend       <= 1'b0;
      words_left <= '0;
    end else if (start_ok) begin
      sr         <= '0;
      bcnt       <= '0;
      pend       <= 1'b0;
      words_left <= i_num_words;
    end else begin
      if (accept) begin
        sr   <= sr_next;
        bcnt <= last_bit ? '0 : bcnt + BW'(1);
      end
      if (last_bit & ~out_free) pend <= 1'b1;
      else if (load_pend)       pend <= 1'b0;
      if (load) words_left <= words_left - NW_W'(1);
    end
  end

  // Output register: holds a word until downstream takes it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      if (load_new)       o_data <= sr_next;
      else if (load_pend) o_data <= sr;
      if (load)       o_valid <= 1'b1;
      else if (drain) o_valid <= 1'b0;
    end
  end

endmodule

// File: doc/xor_word_builder.md
# xor_word_builder

Front end of the XOR correlator and producer side of the pop-count path. Takes two serial bit streams, forms their bitwise XOR, and packs the result MSB-first into WIDTH-bit words. Hands each word downstream (to `pop_count`) with a valid/ready handshake. Runs a programmed number of words per job and pulses `o_done` when the last word has been accepted.

## Interface
Parameters:
- `WIDTH`, 128, word width in bits; power of two, 8..256.
- `NW_W`, 16, width of the word-count input.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  job start; sampled only in IDLE.
- `i_num_words`  in  NW_W  words to build in this job; sampled with `i_start`.
- `i_bit_valid`  in  1  `i_bit_a`/`i_bit_b` carry a bit pair.
- `i_bit_a`  in  1  stream A bit.
- `i_bit_b`  in  1  stream B bit.
- `o_bit_ready`  out  1  builder accepts a bit pair this cycle.
- `o_data`  out  WIDTH  packed XOR word.
- `o_valid`  out  1  `o_data` holds an unaccepted word.
- `i_ready`  in  1  downstream accepts `o_data`.
- `o_busy`  out  1  job in progress (state is not IDLE).
- `o_done`  out  1  one-cycle pulse at job completion.

## Operation
- A bit pair is **accepted** when `i_bit_valid & o_bit_ready`.
- **Packing:**
  - Shift register `sr` shifts left; the new bit `i_bit_a ^ i_bit_b` enters bit 0.
  - A bit counter `bcnt` (0..WIDTH-1) counts accepted pairs.
  - The first accepted bit of a word ends up in `o_data[WIDTH-1]`.
- **Word completion** (the WIDTH-th accepted pair):
  - If the output register is empty, or is being drained this cycle (`o_valid & i_ready`), the completed word is loaded into `o_data`, `o_valid` is set, `bcnt` goes to 0 and `words_left` is decremented.
  - Otherwise the completed word stays in `sr` (pending) and `o_bit_ready` drops until the transfer happens.
- **Output handshake:** `o_data` and `o_valid` hold steady until `o_valid & i_ready`. If no new word is loaded in the accepting cycle, `o_valid` clears the next cycle.
- **State machine:**
  - IDLE → RUN on `i_start` with `i_num_words != 0`; load `words_left`, clear `bcnt`.
  - IDLE → DONE on `i_start` with `i_num_words == 0`.
  - RUN → DRAIN when the last word transfers into `o_data` (`words_left` reaches 0).
  - DRAIN → DONE on `o_valid & i_ready`.
  - DONE → IDLE unconditionally after 1 cycle.
- **`o_bit_ready`:** equals 1 only in RUN and when no completed word is pending in `sr`. It is 0 in IDLE, DRAIN and DONE.
- **Ignored inputs:**
  - `i_start` outside IDLE is ignored.
  - `i_bit_valid` is ignored whenever `o_bit_ready = 0`.
- **Reset:**
  - Asserting `i_reset` at any time, including mid-word or mid-job, returns the block to IDLE.
  - `sr`, `bcnt` and `words_left` clear; any partially built or unaccepted word is discarded.

## Timing
- Reset values: `o_data = 0`, `o_valid = 0`, `o_bit_ready = 0`, `o_busy = 0`, `o_done = 0`.
- `o_bit_ready` rises the cycle after `i_start` is sampled in IDLE.
- `o_valid` rises the cycle after the WIDTH-th bit of a word is accepted, when the output register is free.
- Sustained throughput is 1 bit/cycle: with `i_ready` held at 1, a word is emitted every WIDTH cycles and there are no bubbles at word boundaries.
- A pending word transfers in the same cycle that `o_data` is accepted. `o_bit_ready` returns to 1 on the following cycle.
- `o_done` is high for exactly one cycle:
  - the cycle after the last word is accepted, or
  - the cycle after a start with `i_num_words = 0`.
- `o_busy` is high in RUN, DRAIN and DONE.
- Simultaneous word completion and `o_data` acceptance: the new word replaces the old one, and `o_valid` stays 1 with no gap.

## Configuration
- Macro `XORW_XNOR_EN`.
- Defined: the packed bit is `~(i_bit_a ^ i_bit_b)`. Downstream pop counts then give matches instead of mismatches.
- Undefined: the packed bit is `i_bit_a ^ i_bit_b`.
- All timing and handshake behaviour is identical in both builds.

## Test plan
- **Basic pattern** (WIDTH=128, `i_num_words = 1`, `i_ready = 1`): stream A = 0,1,0,1,…, stream B = 0, 128 pairs → `o_data = 128'h5555…5555` with `o_valid` for 1 cycle, then `o_done` pulse on the next cycle. With `XORW_XNOR_EN` defined, the same stimulus gives `128'hAAAA…AAAA`.
- **Back-to-back words** (`i_num_words = 3`, A = B = 1, `i_ready = 1`): three words of all zeros, `o_valid` pulses 128 cycles apart, `o_bit_ready` never drops during RUN.
- **Backpressure** (`i_num_words = 2`, `i_ready = 0` until 300 cycles after start): after 256 accepted bits `o_bit_ready = 0` and word 1 stays stable. Raising `i_ready` gives word 1 accepted → word 2 loaded the same cycle → `o_done` after word 2 is accepted.
- **Zero-length job** (`i_start` with `i_num_words = 0`): `o_done` pulses on the next cycle, no `o_valid`, `o_busy` is high for exactly 1 cycle.
- **Reset mid-job** (reset after 70 bits of word 1): all outputs return to their reset values immediately. A fresh 1-word job with A = 1, B = 0 then yields `128'hFFFF…FFFF`, with no leftover bits from the aborted word.
- **Start while busy:** `i_start` pulsed during RUN with `i_num_words = 5` is ignored; the original job's word count completes unchanged.
